// File: rtl/fetch_sequencer.sv
// Program-counter owner and single-entry fetch stage: mem_pc -> instr_out in 1 cycle, 1 word/cycle when ready.
// Backpressure: the output stage and PC hold while instr_valid && !instr_ready; a jump flushes the buffered word.
module fetch_sequencer #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH = 5,
  parameter int OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 8'hFF,
  parameter int START_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [PC_WIDTH-1:0]          mem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         jump_valid,
  input  logic [PC_WIDTH-1:0]          jump_target,
  output logic                         halted,
  output logic [15:0]                  fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                load;
  logic                is_halt;
  logic                handshake;

  assign mem_pc    = pc;
  assign load      = (state == FETCH) && (!instr_valid || instr_ready);
  assign is_halt   = (mem_instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
  assign handshake = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (handshake)
        fetch_count <= fetch_count + 16'd1;

      // A redirect discards the wrong-path word even if it is being accepted this cycle.
      if (jump_valid && (state != IDLE)) begin
        pc          <= jump_target;
        instr_valid <= 1'b0;
        state       <= FETCH;
        halted      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= FETCH;
              pc    <= PC_WIDTH'(START_ADDR);
            end
          end
          FETCH: begin
            if (load) begin
              instr_out   <= mem_instruction;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              if (is_halt) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
          HALT: begin
            if (handshake)
              instr_valid <= 1'b0;
            if (start) begin
              state  <= FETCH;
              pc     <= PC_WIDTH'(START_ADDR);
              halted <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, instr_ready, jump_valid;
  logic [4:0]  jump_target;
  logic [4:0]  mem_pc, instr_pc;
  logic [39:0] mem_instruction, instr_out;
  logic        instr_valid, halted;
  logic [15:0] fetch_count;
  logic [39:0] mem [32];
  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mem_pc(mem_pc), .mem_instruction(mem_instruction),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_valid(jump_valid), .jump_target(jump_target), .halted(halted), .fetch_count(fetch_count)
  );

  assign mem_instruction = mem[mem_pc];
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_target = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_out, instr_pc, instr_valid, halted, fetch_count, mem_pc} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: out=%h pc=%0d vld=%b halted=%b cnt=%0d mem_pc=%0d, required all 0",
                 i, instr_out, instr_pc, instr_valid, halted, fetch_count, mem_pc);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_pc !== 5'd0) begin
      errors++; $display("FAIL stream_start: vld=%b mem_pc=%0d, required 0/0", instr_valid, mem_pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_out !== 40'h01_0000_0001 + 40'(i) || instr_pc !== 5'(i) || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_word%0d: out=%h pc=%0d vld=%b, required %h/%0d/1",
                 i, instr_out, instr_pc, instr_valid, 40'h01_0000_0001 + 40'(i), i);
      end
    end
    tick();
    checks++;
    if (fetch_count !== 16'd4) begin
      errors++; $display("FAIL stream_count: got %0d required 4", fetch_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_out !== 40'h01_0000_0003 || instr_pc !== 5'd2 || mem_pc !== 5'd3 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: out=%h pc=%0d mem_pc=%0d vld=%b, required 0100000003/2/3/1",
                 i, instr_out, instr_pc, mem_pc, instr_valid);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_out !== 40'h01_0000_0004 || instr_pc !== 5'd3) begin
      errors++; $display("FAIL bp_resume3: out=%h pc=%0d, required 0100000004/3", instr_out, instr_pc);
    end
    tick();
    checks++;
    if (instr_out !== 40'h01_0000_0005 || instr_pc !== 5'd4 || fetch_count !== 16'd4) begin
      errors++;
      $display("FAIL bp_resume4: out=%h pc=%0d cnt=%0d, required 0100000005/4/4", instr_out, instr_pc, fetch_count);
    end
  endtask

  task automatic test_jump_halt_wrap();
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    instr_ready = 1'b0; jump_valid = 1'b1; jump_target = 5'd5;
    tick();
    jump_valid = 1'b0; instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || mem_pc !== 5'd5 || fetch_count !== 16'd1) begin
      errors++; $display("FAIL jump_flush: vld=%b mem_pc=%0d cnt=%0d, required 0/5/1", instr_valid, mem_pc, fetch_count);
    end
    tick();
    checks++;
    if (instr_out !== 40'h01_0000_0006 || instr_pc !== 5'd5 || instr_valid !== 1'b1 || fetch_count !== 16'd1) begin
      errors++;
      $display("FAIL jump_target: out=%h pc=%0d vld=%b cnt=%0d, required 0100000006/5/1/1",
               instr_out, instr_pc, instr_valid, fetch_count);
    end
    tick();
    checks++;
    if (instr_out !== 40'hFF_0000_0007 || instr_pc !== 5'd6 || halted !== 1'b1 || mem_pc !== 5'd6) begin
      errors++;
      $display("FAIL halt_word: out=%h pc=%0d halted=%b mem_pc=%0d, required ff00000007/6/1/6",
               instr_out, instr_pc, halted, mem_pc);
    end
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b1 || mem_pc !== 5'd6 || fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL halt_stop: vld=%b halted=%b mem_pc=%0d cnt=%0d, required 0/1/6/3",
               instr_valid, halted, mem_pc, fetch_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || mem_pc !== 5'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL halt_restart: halted=%b mem_pc=%0d vld=%b, required 0/0/0", halted, mem_pc, instr_valid);
    end
    tick();
    checks++;
    if (instr_out !== 40'h01_0000_0001 || instr_pc !== 5'd0 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL restart_word: out=%h pc=%0d vld=%b, required 0100000001/0/1", instr_out, instr_pc, instr_valid);
    end
    jump_valid = 1'b1; jump_target = 5'd31;
    tick();
    jump_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_pc !== 5'd31 || fetch_count !== 16'd4) begin
      errors++; $display("FAIL wrap_jump: vld=%b mem_pc=%0d cnt=%0d, required 0/31/4", instr_valid, mem_pc, fetch_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_pc !== 5'(31 + i) || instr_out !== mem[5'(31 + i)] || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_seq%0d: pc=%0d out=%h vld=%b, required pc %0d", i, instr_pc, instr_out, instr_valid, 5'(31 + i));
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0; jump_valid = 1'b1; jump_target = 5'd8;
    tick();
    jump_valid = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || mem_pc !== 5'd9 || instr_pc !== 5'd8) begin
      errors++; $display("FAIL mid_setup: vld=%b mem_pc=%0d pc=%0d, required 1/9/8", instr_valid, mem_pc, instr_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({instr_out, instr_pc, instr_valid, halted, fetch_count, mem_pc} !== '0) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: out=%h pc=%0d vld=%b halted=%b cnt=%0d mem_pc=%0d, required all 0",
                 i, instr_out, instr_pc, instr_valid, halted, fetch_count, mem_pc);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 40'h01_0000_0001 + 40'(i);
    mem[6] = 40'hFF_0000_0007;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_target = '0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_halt_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller for the program memory. It owns the program counter, drives the memory's address port, and registers each returned instruction into a single-entry output stage with a valid/ready handshake toward decode. It also handles start, jump redirect with wrong-path flush, and halt-opcode detection. It sits between the instruction memory (combinational read, `mem_pc` → `mem_instruction` in the same cycle) and the decode/execute stage.

## Interface

Parameters:
- `INSTRUCTION_WIDTH`, 40: instruction word width.
- `PC_WIDTH`, 5: program counter width; address space is 2^PC_WIDTH words.
- `OPCODE_WIDTH`, 8: opcode field, bits [INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH].
- `HALT_OPCODE`, 8'hFF: opcode value that stops fetching.
- `START_ADDR`, 0: PC value loaded on start.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle pulse that begins or restarts fetching at `START_ADDR`.
- `mem_pc`, output, PC_WIDTH: address to the instruction memory; equals the internal PC.
- `mem_instruction`, input, INSTRUCTION_WIDTH: memory read data for `mem_pc`, valid in the same cycle.
- `instr_out`, output, INSTRUCTION_WIDTH: registered instruction.
- `instr_pc`, output, PC_WIDTH: address `instr_out` was fetched from.
- `instr_valid`, output, 1: `instr_out` holds an undelivered instruction.
- `instr_ready`, input, 1: consumer accepts `instr_out` this cycle.
- `jump_valid`, input, 1: redirect request from execute.
- `jump_target`, input, PC_WIDTH: redirect address.
- `halted`, output, 1: high while in HALT.
- `fetch_count`, output, 16: count of accepted handshakes.

## Operation

- States:
  - IDLE: after reset. Does not fetch.
  - FETCH: fetches instructions.
  - HALT: stopped on a halt opcode.
- Reset: state IDLE, `pc` = 0, `mem_pc` = 0, `instr_out` = 0, `instr_pc` = 0, `instr_valid` = 0, `halted` = 0, `fetch_count` = 0. Reset overrides every other input, including in mid-stream.
- IDLE:
  - `start` → FETCH, `pc` ← START_ADDR.
  - `jump_valid` is ignored.
- FETCH, load condition `load = !instr_valid || instr_ready`:
  - On `load`: `instr_out` ← `mem_instruction`, `instr_pc` ← `pc`, `instr_valid` ← 1, `pc` ← `pc`+1.
  - PC increment wraps modulo 2^PC_WIDTH (2^PC_WIDTH−1 → 0).
  - Without `load`: every register holds (backpressure).
- Halt detection:
  - Applies when the word being loaded has opcode == HALT_OPCODE.
  - The halt word is still delivered.
  - `pc` does not increment.
  - Next state is HALT and `halted` ← 1.
- HALT:
  - No further loads. The buffered halt word drains through the normal handshake.
  - `start` → FETCH, `pc` ← START_ADDR, `halted` ← 0.
- Jump, in FETCH or HALT, has the highest priority after reset:
  - `pc` ← `jump_target`, `instr_valid` ← 0. The buffered wrong-path word is discarded; no load occurs that cycle.
  - State ← FETCH, `halted` ← 0.
  - `start` in the same cycle is ignored.
- Counter:
  - `fetch_count` increments on every cycle with `instr_valid && instr_ready`, including a cycle with simultaneous `jump_valid`.
  - Wraps at 2^16.

## Timing

- Address-to-output latency is 1 cycle: `mem_pc` = A in cycle n gives `instr_out` = mem[A] and `instr_valid` = 1 after edge n.
- `start` sampled at edge E0 puts the first word (START_ADDR) on `instr_out` after E1.
- With `instr_ready` held high, throughput is 1 instruction per cycle with no bubbles.
- Jump sampled at edge E gives `instr_valid` = 0 after E. mem[`jump_target`] appears after E+1, so there is a 1-cycle bubble.
- `instr_out` and `instr_pc` are stable while `instr_valid && !instr_ready`.
- `mem_pc` is a direct register output with no combinational path from any input.

## Test plan

1. Reset then idle:
   - Stimulus: `rst` = 1 for 2 cycles, then 5 idle cycles.
   - Required: all outputs 0 and `mem_pc` = 0 throughout.
2. Straight-line stream:
   - Stimulus: mem[0..3] = 40'h01_0000_0001..40'h01_0000_0004, `start` pulse, `instr_ready` = 1.
   - Required: `instr_out` = those words on 4 consecutive cycles, `instr_pc` = 0,1,2,3, `fetch_count` = 4.
3. Backpressure:
   - Stimulus: `instr_ready` = 0 for 3 cycles while the word from address 2 is valid.
   - Required: `instr_out`/`instr_pc` hold mem[2]/2 and `mem_pc` stays 3.
   - After `instr_ready` returns to 1: mem[3] follows with no loss or duplication.
4. Jump flush:
   - Stimulus: `jump_valid` with `jump_target` = 5 while mem[1] is valid and `instr_ready` = 0.
   - Required: `instr_valid` = 0 the next cycle, then `instr_out` = mem[5], `instr_pc` = 5.
   - Required: `fetch_count` unchanged.
5. Halt and wrap:
   - Halt stimulus: mem[6] opcode 8'hFF.
   - Required: mem[6] is delivered, then `halted` = 1, no further loads, `mem_pc` = 6. A `start` pulse resumes at address 0.
   - Wrap stimulus: jump to 31 with PC_WIDTH = 5.
   - Required: fetched `instr_pc` sequence is 31, 0, 1.
6. Reset mid-stream:
   - Stimulus: assert `rst` while `instr_valid` = 1 and `pc` = 9.
   - Required: after the edge, all outputs are 0, state is IDLE, and no fetch occurs until `start`.
